// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants and types for the FP16 adder normalise/round stage.
// Optional flag output controlled by FP16_ADD_FLAGS_EN (see fp16_add_normalize).
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int ADD_FRAC_W   = 13;

    // Packed IEEE half-precision word.
    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_FRAC_W-1:0] frac;
    } fp16_t;

    // Exception flags carried alongside a result.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } add_flags_t;

    // Assemble an FP16 word from its fields.
    function automatic fp16_t fp16_pack(input logic                   sign,
                                        input logic [FP16_EXP_W-1:0]  exp,
                                        input logic [FP16_FRAC_W-1:0] frac);
        fp16_t w;
        w.sign = sign;
        w.exp  = exp;
        w.frac = frac;
        return w;
    endfunction

endpackage

// File: rtl/fp16_add_normalize_if.sv
// fp16_add_normalize_if: input (fraction-sum) and output (packed FP16) channels
// of the normalise stage. out_flags exists only with FP16_ADD_FLAGS_EN.
interface fp16_add_normalize_if;
    import fp16_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [ADD_FRAC_W-1:0] in_sum;
    logic                  in_carry;
    logic [FP16_EXP_W-1:0] in_exp;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
`ifdef FP16_ADD_FLAGS_EN
    logic [2:0]            out_flags;

    modport master (
        output in_valid, in_sign, in_sum, in_carry, in_exp, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_sum, in_carry, in_exp, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
`else
    modport master (
        output in_valid, in_sign, in_sum, in_carry, in_exp, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sign, in_sum, in_carry, in_exp, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/fp16_add_normalize_lzc_13b.sv
// lzc_13b: combinational leading-zero counter for the 13-bit sum magnitude.
// Returns 13 for an all-zero input.
module lzc_13b (
    input  logic [12:0] data_i,
    output logic [3:0]  count_o
);

    // Priority encode the most significant set bit.
    always_comb begin
        count_o = 4'd13;
        casez (data_i)
            13'b1????????????: count_o = 4'd0;
            13'b01???????????: count_o = 4'd1;
            13'b001??????????: count_o = 4'd2;
            13'b0001?????????: count_o = 4'd3;
            13'b00001????????: count_o = 4'd4;
            13'b000001???????: count_o = 4'd5;
            13'b0000001??????: count_o = 4'd6;
            13'b00000001?????: count_o = 4'd7;
            13'b000000001????: count_o = 4'd8;
            13'b0000000001???: count_o = 4'd9;
            13'b00000000001??: count_o = 4'd10;
            13'b000000000001?: count_o = 4'd11;
            13'b0000000000001: count_o = 4'd12;
            default:           count_o = 4'd13;
        endcase
    end

endmodule

// File: rtl/fp16_add_normalize.sv
// fp16_add_normalize: two-stage normalise (A) and round/pack (B) pipeline that
// turns the fraction-add result into an FP16 word, round-to-nearest-even,
// overflow to Inf, flush-to-zero on underflow.
// Define FP16_ADD_FLAGS_EN to add the {overflow, underflow, inexact} output.
module fp16_add_normalize
    import fp16_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fp16_add_normalize_if.slave  bus
);

    // Stage A registers: normalised mantissa with guard/sticky in [1:0].
    logic                  a_valid_q, a_valid_d;
    logic                  a_sign_q,  a_sign_d;
    logic                  a_zero_q,  a_zero_d;
    logic [6:0]            a_exp_q,   a_exp_d;   // two's-complement exponent
    logic [ADD_FRAC_W-1:0] a_norm_q,  a_norm_d;

    // Stage B registers: packed result.
    logic                  b_valid_q, b_valid_d;
    fp16_t                 b_data_q,  b_data_d;
`ifdef FP16_ADD_FLAGS_EN
    add_flags_t            b_flags_q, b_flags_d;
`endif

    logic [3:0]            lz_s;
    logic                  a_load_s;
    logic                  a_adv_s;
    logic                  in_ready_s;
    logic [10:0]           m_s;
    logic                  g_s;
    logic                  sticky_s;
    logic                  rnd_up_s;
    logic [11:0]           m_rnd_s;
    logic [6:0]            exp_rnd_s;
    logic [FP16_FRAC_W-1:0] frac_rnd_s;
    logic                  ovf_s;
    logic                  unf_s;
    fp16_t                 result_s;

    lzc_13b u_lzc (
        .data_i  (bus.in_sum),
        .count_o (lz_s)
    );

    // A advances whenever B is empty or B's beat leaves this cycle.
    assign a_adv_s    = a_valid_q && (!b_valid_q || bus.out_ready);
    assign in_ready_s = !a_valid_q || a_adv_s;
    assign a_load_s   = bus.in_valid && in_ready_s;

    // Stage A next state: normalise the incoming sum.
    always_comb begin
        a_sign_d = bus.in_sign;
        a_zero_d = 1'b0;
        a_norm_d = '0;
        a_exp_d  = 7'd0;
        if (bus.in_carry) begin
            // Carry-out: shift right one, folding the dropped bit into sticky.
            a_norm_d = {1'b1, bus.in_sum[12:2], bus.in_sum[1] | bus.in_sum[0]};
            a_exp_d  = {2'b00, bus.in_exp} + 7'd1;
        end else if (lz_s == 4'd13) begin
            // Exact cancellation always yields +0.
            a_zero_d = 1'b1;
            a_sign_d = 1'b0;
        end else begin
            a_norm_d = bus.in_sum << lz_s;
            a_exp_d  = {2'b00, bus.in_exp} - {3'b000, lz_s};
        end
    end

    // Stage B datapath: round-to-nearest-even and range handling.
    always_comb begin
        m_s        = a_norm_q[12:2];
        g_s        = a_norm_q[1];
        sticky_s   = a_norm_q[0];
        rnd_up_s   = g_s && (sticky_s || m_s[0]);
        m_rnd_s    = {1'b0, m_s} + {11'd0, rnd_up_s};
        exp_rnd_s  = a_exp_q + {6'd0, m_rnd_s[11]};
        ovf_s      = 1'b0;
        unf_s      = 1'b0;
        result_s   = '0;
        if (m_rnd_s[11]) begin
            // Rounded up to 2.0: mantissa becomes 1.0 at the next exponent.
            frac_rnd_s = '0;
        end else begin
            frac_rnd_s = m_rnd_s[FP16_FRAC_W-1:0];
        end
        if (a_zero_q) begin
            result_s = '0;
        end else if ($signed(exp_rnd_s) >= $signed(7'(FP16_EXP_MAX))) begin
            ovf_s    = 1'b1;
            result_s = fp16_pack(a_sign_q, 5'h1F, 10'h000);
        end else if ($signed(exp_rnd_s) <= $signed(7'd0)) begin
            unf_s    = 1'b1;
            result_s = fp16_pack(a_sign_q, 5'h00, 10'h000);
        end else begin
            result_s = fp16_pack(a_sign_q, exp_rnd_s[FP16_EXP_W-1:0], frac_rnd_s);
        end
    end

    // Pipeline next-state: load A on input handshake, B when A advances.
    always_comb begin
        if (a_load_s) begin
            a_valid_d = 1'b1;
        end else if (a_adv_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end

        b_data_d = b_data_q;
`ifdef FP16_ADD_FLAGS_EN
        b_flags_d = b_flags_q;
`endif
        if (a_adv_s) begin
            b_valid_d = 1'b1;
            b_data_d  = result_s;
`ifdef FP16_ADD_FLAGS_EN
            b_flags_d.overflow  = ovf_s;
            b_flags_d.underflow = unf_s;
            b_flags_d.inexact   = g_s | sticky_s | ovf_s | unf_s;
`endif
        end else if (bus.out_ready) begin
            b_valid_d = 1'b0;
        end else begin
            b_valid_d = b_valid_q;
        end
    end

    // State registers with synchronous reset discarding in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_sign_q  <= 1'b0;
            a_zero_q  <= 1'b0;
            a_exp_q   <= 7'd0;
            a_norm_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
`ifdef FP16_ADD_FLAGS_EN
            b_flags_q <= '0;
`endif
        end else begin
            a_valid_q <= a_valid_d;
            if (a_load_s) begin
                a_sign_q <= a_sign_d;
                a_zero_q <= a_zero_d;
                a_exp_q  <= a_exp_d;
                a_norm_q <= a_norm_d;
            end
            b_valid_q <= b_valid_d;
            b_data_q  <= b_data_d;
`ifdef FP16_ADD_FLAGS_EN
            b_flags_q <= b_flags_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = b_valid_q;
    assign bus.out_data  = b_data_q;
`ifdef FP16_ADD_FLAGS_EN
    assign bus.out_flags = b_flags_q;
`endif

endmodule

// File: doc/fp16_add_normalize.md
Name: fp16_add_normalize

Overview:
- Final stage of the FP16 adder used by the systolic-array MAC unit.
- Consumes the signed-fraction sum produced by the fraction-add stage (sign, 13-bit magnitude, carry, max exponent).
- Normalises and rounds that sum (round-to-nearest-even) and packs an IEEE FP16 word.
- Two-stage pipeline with valid/ready handshake on both sides, so the MAC array can stall it.

Parameters:
- None; widths fixed by the FP16 format (constants come from the package).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_sign  in  1  sign of the sum
- in_sum  in  13  magnitude; bit12 = hidden bit, [11:2] fraction, [1] guard, [0] sticky
- in_carry  in  1  carry-out of the fraction add (true magnitude = {in_carry, in_sum})
- in_exp  in  5  biased max exponent from alignment
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  16  packed FP16 {sign, exp[4:0], frac[9:0]}
- out_flags  out  3  {overflow, underflow, inexact}; present only with FP16_ADD_FLAGS_EN

Behaviour:
- Reset (synchronous, active-high):
  - Both stage-valid bits clear; out_valid=0, out_data=0, out_flags=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats.
- Handshake:
  - A beat transfers when valid && ready.
  - Stage A loads when in_valid && in_ready.
  - Stage B loads when A is valid and (B is empty or out_ready).
  - in_ready = !A_valid || A_advances; this path is combinational.
  - out_data is stable while out_valid && !out_ready.
  - Latency is 2 cycles with no stall. Throughput is 1 beat/cycle. Beat order is preserved and no beat is lost or duplicated.
- Stage A (normalise):
  - Exponent arithmetic is done as 7-bit signed.
  - Carry=1: mantissa is {1, in_sum[12:1]}; in_sum[0] is ORed into sticky; exp = in_exp+1.
  - Carry=0 and in_sum=0: zero result; +0 (sign forced 0).
  - Otherwise: lz = leading zeros of in_sum (0..12). Shift left by lz, exp = in_exp-lz. Bits shifted in are 0.
- Stage B (round/pack):
  - m = norm[12:2], g = norm[1], s = norm[0].
  - Round up iff g && (s || m[0]).
  - If rounding carries out of m (0x800), then m = 0x400 and exp += 1.
  - exp ≥ 31: result is ±Inf (sign,5'h1F,0).
  - exp ≤ 0: flush to zero, ±0 with sign kept. No subnormal output.
  - Otherwise: {sign, exp[4:0], m[9:0]}.
- Input exponent 0 is treated as exponent 0 (subnormals were flushed upstream); in_exp=0 with nonzero sum follows the exp ≤ 0 rule.

Optional Feature:
- Macro: FP16_ADD_FLAGS_EN.
- Defined: out_flags exists and travels with out_data.
  - overflow = Inf produced by the exp ≥ 31 rule.
  - underflow = flush-to-zero of a nonzero sum.
  - inexact = g|s before rounding, or overflow, or underflow.
- Undefined: port absent; no flag logic or flag pipeline registers.

Decomposition:
- Package fp16_pkg:
  - Constants FP16_EXP_W=5, FP16_FRAC_W=10, FP16_BIAS=15, FP16_EXP_MAX=31, ADD_FRAC_W=13.
  - typedef fp16_t as a packed struct {sign, exp, frac}.
  - typedef add_flags_t as a packed struct {overflow, underflow, inexact}.
- Sub-module lzc_13b: combinational 13-bit leading-zero counter, 4-bit count, 13 returned for an all-zero input. Instanced in stage A.

Test Plan:
- 1.0+1.0: in_sum=0x0000, in_carry=1, in_exp=15, sign 0 -> out_data=0x4000 two cycles later.
- Cancellation: in_sum=0x0800, carry=0, exp=15 -> 0x3800. in_sum=0, carry=0, sign=1 -> 0x0000.
- RNE:
  - in_sum=0x1006, exp=15 -> 0x3C02 (tie, odd, rounds up).
  - in_sum=0x1002 -> 0x3C00 (tie, even, stays).
  - in_sum=0x1FFE -> 0x4000 (mantissa carry). Inexact set when FP16_ADD_FLAGS_EN.
- Overflow/underflow:
  - carry=1, exp=30 -> 0x7C00, overflow flag.
  - in_sum=0x0800, exp=1, sign=1 -> 0x8000, underflow flag.
- Backpressure: stream 5 beats back-to-back with out_ready low for 4 cycles -> in_ready drops after 2 beats are accepted; all 5 outputs appear in order with none lost or duplicated; out_data holds steady during the stall.
- Reset mid-stream: assert rst with both stages full -> next cycle out_valid=0, in_ready=1; old beats never emerge.
